// File: rtl/sha256_round_ctrl_if.sv
// rtl/sha256_round_ctrl_if.sv - block, digest and round-unit signal bundle for sha256_round_ctrl
interface sha256_round_ctrl_if;
    logic                in_valid;
    logic                in_ready;
    logic [15:0][31:0]   in_block;
    logic [7:0][31:0]    in_h;
`ifdef SHA256_ROUND_CTRL_CHAIN_EN
    logic                in_first;
`endif
    logic                out_valid;
    logic                out_ready;
    logic [7:0][31:0]    out_digest;
    logic                busy;
    logic                err;
    logic [7:0][31:0]    rnd_letters;
    logic [5:0]          rnd_counter;
    logic [3:0][31:0]    rnd_w;
    logic                rnd_valid;
    logic [7:0][31:0]    rnd_letters_in;
    logic                rnd_letters_valid;
    logic [31:0]         rnd_w_in;
    logic                rnd_w_valid;

    // master: the round controller itself
    modport master (
        input  in_valid, in_block, in_h,
`ifdef SHA256_ROUND_CTRL_CHAIN_EN
        input  in_first,
`endif
        input  out_ready, rnd_letters_in, rnd_letters_valid, rnd_w_in, rnd_w_valid,
        output in_ready, out_valid, out_digest, busy, err,
        output rnd_letters, rnd_counter, rnd_w, rnd_valid
    );

    // slave: block source, digest sink and round unit around the controller
    modport slave (
        output in_valid, in_block, in_h,
`ifdef SHA256_ROUND_CTRL_CHAIN_EN
        output in_first,
`endif
        output out_ready, rnd_letters_in, rnd_letters_valid, rnd_w_in, rnd_w_valid,
        input  in_ready, out_valid, out_digest, busy, err,
        input  rnd_letters, rnd_counter, rnd_w, rnd_valid
    );
endinterface

// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - SHA-256 round sequencer with W ring buffer; SHA256_ROUND_CTRL_CHAIN_EN adds block chaining
module sha256_round_ctrl #(
    parameter int ROUND_LAT = 5,
    parameter int WDOG_CYC  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sha256_round_ctrl_if.master  bus
);
    // The stall bound is never allowed below the nominal round latency.
    localparam int WDOG_LIM = (WDOG_CYC > ROUND_LAT) ? WDOG_CYC : ROUND_LAT;
    localparam int WD_W     = $clog2(WDOG_LIM + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FINAL, DONE} state_t;
    state_t state, state_nxt;

    logic [7:0][31:0]  h_reg, l_reg, lat_l, digest_r, rnd_letters_r, init_h, l_new;
    logic [15:0][31:0] sched;
    logic [3:0][31:0]  rnd_w_r, win_nxt;
    logic [5:0]        t_reg, rnd_counter_r;
    logic [31:0]       lat_w, w_new;
    logic              got_l, got_w, have_l, have_w, rnd_done, err_r;
    logic [WD_W-1:0]   wd_cnt;

    // W window for round tt; for tt<16 only the raw message word is passed,
    // so the round unit's sigma terms see zero and W[tt] = M[tt].
    function automatic logic [3:0][31:0] window(input logic [5:0] tt,
                                                input logic [15:0][31:0] s);
        logic [3:0][31:0] w;
        logic [3:0] i0, i1, i9, i14;
        i0  = tt[3:0];
        i1  = tt[3:0] + 4'd1;
        i9  = tt[3:0] + 4'd9;
        i14 = tt[3:0] + 4'd14;
        w = '0;
        w[0] = s[i0];
        if (tt >= 6'd16) begin
            w[1] = s[i1];
            w[2] = s[i9];
            w[3] = s[i14];
        end
        return w;
    endfunction

    // Result capture: a valid in the current cycle wins over a latched copy.
    always_comb begin
`ifdef SHA256_ROUND_CTRL_CHAIN_EN
        init_h = bus.in_first ? bus.in_h : digest_r;
`else
        init_h = bus.in_h;
`endif
        have_l   = got_l | bus.rnd_letters_valid;
        have_w   = got_w | bus.rnd_w_valid;
        l_new    = bus.rnd_letters_valid ? bus.rnd_letters_in : lat_l;
        w_new    = bus.rnd_w_valid ? bus.rnd_w_in : lat_w;
        rnd_done = (state == WAIT) && have_l && have_w;
        // Slot t%16 is never part of round t+1's window, so no forwarding of w_new.
        win_nxt  = window(t_reg + 6'd1, sched);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and state-decoded handshake outputs.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.rnd_valid = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.rnd_valid = 1'b1;
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (rnd_done) state_nxt = (t_reg == 6'd63) ? FINAL : ISSUE;
            end
            FINAL: state_nxt = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: block load, result collection, schedule update, final add, watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_reg         <= '0;
            l_reg         <= '0;
            lat_l         <= '0;
            lat_w         <= '0;
            sched         <= '0;
            t_reg         <= '0;
            got_l         <= 1'b0;
            got_w         <= 1'b0;
            wd_cnt        <= '0;
            err_r         <= 1'b0;
            digest_r      <= '0;
            rnd_letters_r <= '0;
            rnd_counter_r <= '0;
            rnd_w_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        h_reg         <= init_h;
                        l_reg         <= init_h;
                        sched         <= bus.in_block;
                        t_reg         <= '0;
                        rnd_letters_r <= init_h;
                        rnd_counter_r <= '0;
                        rnd_w_r       <= {96'd0, bus.in_block[0]};
                    end
                end
                ISSUE: begin
                    got_l  <= 1'b0;
                    got_w  <= 1'b0;
                    wd_cnt <= '0;
                end
                WAIT: begin
                    if (wd_cnt >= WD_W'(WDOG_LIM)) err_r <= 1'b1;
                    else                          wd_cnt <= wd_cnt + 1'b1;
                    if (rnd_done) begin
                        got_l <= 1'b0;
                        got_w <= 1'b0;
                        l_reg <= l_new;
                        if (t_reg >= 6'd16) sched[t_reg[3:0]] <= w_new;
                        if (t_reg != 6'd63) begin
                            t_reg         <= t_reg + 6'd1;
                            rnd_letters_r <= l_new;
                            rnd_counter_r <= t_reg + 6'd1;
                            rnd_w_r       <= win_nxt;
                        end
                    end else begin
                        if (bus.rnd_letters_valid) begin
                            got_l <= 1'b1;
                            lat_l <= bus.rnd_letters_in;
                        end
                        if (bus.rnd_w_valid) begin
                            got_w <= 1'b1;
                            lat_w <= bus.rnd_w_in;
                        end
                    end
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) digest_r[i] <= h_reg[i] + l_reg[i];
                end
                default: ;
            endcase
        end
    end

    assign bus.out_digest  = digest_r;
    assign bus.err         = err_r;
    assign bus.rnd_letters = rnd_letters_r;
    assign bus.rnd_counter = rnd_counter_r;
    assign bus.rnd_w       = rnd_w_r;
endmodule
